serial_frame_collector: RTL and testbench
=========================================

# serial_frame_collector

Downstream consumer of the single-bit `out` stream produced by the generated serial datapath (`source`). It hunts the stream for a sync word, deserializes the following data word MSB-first, and checks a trailing even-parity bit. Good words are buffered in a small FIFO and offered on a valid/ready byte interface; errors and overflow are flagged with single-cycle pulses.

## Interface
- `DATA_W`, 8: data word width in bits.
- `SYNC_W`, 8: sync word width in bits.
- `SYNC`, 8'hA5: sync pattern, MSB received first.
- `DEPTH`, 4: FIFO depth in words; power of two, at least 2.
- `clock` input 1: single clock; all state changes on its rising edge.
- `reset_n` input 1: asynchronous active-low reset.
- `bit_in` input 1: serial data bit (the upstream `out`).
- `bit_valid` input 1: `bit_in` is sampled only when this is 1.
- `out_data` output DATA_W: head-of-FIFO word; shown ahead, valid while `out_valid`=1.
- `out_valid` output 1: FIFO non-empty.
- `out_ready` input 1: consumer accepts `out_data` when `out_valid` & `out_ready`.
- `parity_err` output 1: one-cycle pulse; parity mismatch, frame dropped.
- `overflow` output 1: one-cycle pulse; good frame dropped because the FIFO was full.
- `frame_cnt` output 8: count of words written to the FIFO; wraps 255 -> 0.

## Operation
- Reset: all outputs 0; state HUNT; sync shift register, bit counter, FIFO pointers and count cleared.
- State HUNT:
  - On each valid bit, `sr <= {sr[SYNC_W-2:0], bit_in}`.
  - If the new `sr` value equals `SYNC`, go to DATA with bit counter 0.
- State DATA:
  - Each valid bit shifts into the data register MSB-first.
  - After DATA_W valid bits, go to PARITY.
- State PARITY:
  - The next valid bit is the parity bit `p`.
  - Frame is good when `p == ^data`, i.e. even total ones count.
  - Good frame with FIFO not full, or full with a pop in the same cycle: write the word and increment `frame_cnt`.
  - Good frame with FIFO full and no pop: drop the word and pulse `overflow`.
  - Bad parity: drop the word and pulse `parity_err`.
  - In every case, return to HUNT and clear `sr` to 0, so sync never overlaps the previous frame.
- `bit_valid`=0 holds all serial state; gaps of any length are legal in any state.
- FIFO:
  - Circular buffer with DEPTH entries; read and write pointers wrap modulo DEPTH.
  - Occupancy count ranges 0..DEPTH.
  - Pop occurs when `out_valid` & `out_ready`.
  - A simultaneous push and pop leaves the count unchanged; this is legal at both empty and full.
  - `out_ready` while empty is ignored.
- Reset mid-frame or with FIFO contents discards everything; there is no partial output.

## Timing
- Sync match, data bits and parity bit are each registered on the rising edge where `bit_valid`=1.
- FIFO write happens on the same edge that samples the parity bit.
- `out_valid` and `out_data` change on the edge after the last bit, so latency from the parity bit to `out_valid` is 1 cycle.
- `parity_err` and `overflow` are high for exactly the cycle following the parity-bit edge.
- Minimum frame length: SYNC_W + DATA_W + 1 valid bits; back-to-back frames need no idle bits.
- Pop takes effect on the accepting edge; the next head word, or `out_valid`=0, is visible in the following cycle.
- Reset asserts asynchronously, with outputs going to 0 immediately; deassertion is sampled on the clock.

## Test plan
- Reset check: hold `reset_n`=0 with random `bit_in` -> `out_valid`, `parity_err`, `overflow` and `frame_cnt` all stay 0. Release reset and send 30 zero bits -> no output.
- Good frame: bits `10100101 00111100 0` with `out_ready`=1 -> `out_data`=8'h3C, `out_valid` high for 1 cycle, 1 cycle after the parity bit; `frame_cnt`=1.
- Bad parity and false sync: bits `1010 10100101 11110000 1` -> sync found on the second pattern only; `parity_err` pulses once; FIFO stays empty.
- Overflow and ordering: `out_ready`=0, send 5 good frames with data 01, 02, 03, 04, 05 -> `overflow` pulses on the fifth. Then raise `out_ready` -> reads 01, 02, 03, 04 in order; `frame_cnt`=4.
- Simultaneous push/pop at full: FIFO full with `out_ready` pulsed on the parity-bit edge of a new good frame -> no overflow; count stays 4; new word is last out.
- Gaps and reset: `bit_valid` toggled randomly during a frame -> same result as the gapless case. Assert `reset_n` mid-DATA, then send a full frame -> only the post-reset word appears.

Source files
------------

// File: rtl/serial_frame_collector.sv
// Hunts a serial bit stream for a sync word, deserializes the following word MSB-first,
// checks a trailing even-parity bit and buffers good words in a small FIFO.
module serial_frame_collector #(
    parameter int                DATA_W = 8,
    parameter int                SYNC_W = 8,
    parameter logic [SYNC_W-1:0] SYNC   = 8'hA5,
    parameter int                DEPTH  = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              bit_in,
    input  logic              bit_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              parity_err,
    output logic              overflow,
    output logic [7:0]        frame_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {HUNT, DATA, PARITY} state_t;

    state_t             state, state_next;
    logic [SYNC_W-1:0]  sr, sr_shift;
    logic [DATA_W-1:0]  data_reg;
    logic [CNT_W-1:0]   bit_cnt;
    logic [DATA_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [PTR_W:0]     count;
    logic               full, pop, push, good, frame_end;

    assign sr_shift  = (sr << 1) | {{(SYNC_W-1){1'b0}}, bit_in};
    assign full      = (count == FULL_CNT);
    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready;
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            state <= HUNT;
        else
            state <= state_next;
    end

    // A pop on the parity edge frees a slot, so a full FIFO can still accept the word.
    always_comb begin
        state_next = state;
        frame_end  = 1'b0;
        good       = 1'b0;
        push       = 1'b0;
        case (state)
            HUNT: begin
                if (bit_valid && sr_shift == SYNC)
                    state_next = DATA;
            end
            DATA: begin
                if (bit_valid && bit_cnt == LAST_BIT)
                    state_next = PARITY;
            end
            PARITY: begin
                if (bit_valid) begin
                    frame_end  = 1'b1;
                    good       = (bit_in == ^data_reg);
                    push       = good && (!full || pop);
                    state_next = HUNT;
                end
            end
            default: state_next = HUNT;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sr         <= '0;
            data_reg   <= '0;
            bit_cnt    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            parity_err <= 1'b0;
            overflow   <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            parity_err <= frame_end && !good;
            overflow   <= frame_end && good && !push;
            if (bit_valid) begin
                case (state)
                    HUNT: begin
                        sr      <= sr_shift;
                        bit_cnt <= '0;
                    end
                    DATA: begin
                        data_reg <= {data_reg[DATA_W-2:0], bit_in};
                        bit_cnt  <= bit_cnt + 1'b1;
                    end
                    // Clearing sr keeps the next sync search from reusing frame bits.
                    PARITY: sr <= '0;
                    default: sr <= '0;
                endcase
            end
            if (push) begin
                wr_ptr    <= wr_ptr + 1'b1;
                frame_cnt <= frame_cnt + 8'd1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push)
            mem[wr_ptr] <= data_reg;
    end

endmodule

// File: tb/tb_serial_frame_collector.sv
// Randomized and directed bench for serial_frame_collector; a bit-queue reference model
// feeds a scoreboard that an independent monitor drains as the DUT presents results.
module tb_serial_frame_collector;

    localparam int DATA_W = 8;
    localparam int SYNC_W = 8;
    localparam int DEPTH  = 4;
    localparam logic [SYNC_W-1:0] SYNC = 8'hA5;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              bit_in = 1'b0;
    logic              bit_valid = 1'b0;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              parity_err;
    logic              overflow;
    logic [7:0]        frame_cnt;

    int n_compared = 0;
    int n_failed   = 0;

    typedef struct {int cyc; bit ovf;} pulse_t;

    bit                hist[$];
    logic [DATA_W-1:0] exp_q[$];
    pulse_t            pulse_q[$];
    int                rise_q[$];
    int                model_cnt = 0;
    logic [7:0]        model_frames = 8'd0;
    int                cyc = 0;

    serial_frame_collector #(
        .DATA_W(DATA_W), .SYNC_W(SYNC_W), .SYNC(SYNC), .DEPTH(DEPTH)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .bit_in(bit_in),
        .bit_valid(bit_valid),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .parity_err(parity_err),
        .overflow(overflow),
        .frame_cnt(frame_cnt)
    );

    always #5 clock = ~clock;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Index of the bit completing the first sync window; bits before the search start read as 0.
    function automatic int sync_end();
        logic [SYNC_W-1:0] w;
        for (int e = 0; e < hist.size(); e++) begin
            w = '0;
            for (int k = SYNC_W - 1; k >= 0; k--)
                w = (w << 1) | ((e - k >= 0) ? SYNC_W'(hist[e-k]) : '0);
            if (w == SYNC)
                return e;
        end
        return -1;
    endfunction

    // Reference model: collects valid bits, recognises a complete frame by searching the bit history.
    initial begin
        forever begin
            @(posedge clock or negedge reset_n);
            if (!reset_n) begin
                hist.delete();
                exp_q.delete();
                pulse_q.delete();
                rise_q.delete();
                model_cnt    = 0;
                model_frames = 8'd0;
            end else begin
                bit                pop_now;
                bit                push_now;
                int                e;
                int                ones;
                logic [DATA_W-1:0] d;
                cyc++;
                pop_now  = (model_cnt > 0) && out_ready;
                push_now = 1'b0;
                if (bit_valid) begin
                    hist.push_back(bit_in);
                    e = sync_end();
                    if (e >= 0 && hist.size() == e + DATA_W + 2) begin
                        d = '0;
                        for (int i = 1; i <= DATA_W; i++)
                            d = (d << 1) | DATA_W'(hist[e+i]);
                        ones = $countones(d) + int'(hist[hist.size()-1]);
                        if (ones % 2 != 0) begin
                            pulse_q.push_back('{cyc, 1'b0});
                        end else if (model_cnt < DEPTH || pop_now) begin
                            push_now = 1'b1;
                            exp_q.push_back(d);
                            model_frames++;
                            if (model_cnt == 0)
                                rise_q.push_back(cyc);
                        end else begin
                            pulse_q.push_back('{cyc, 1'b1});
                        end
                        hist.delete();
                    end
                end
                model_cnt = model_cnt + int'(push_now) - int'(pop_now);
            end
        end
    end

    // Monitor: compares whatever the DUT presents against the scoreboard queues.
    initial begin
        bit     prev_valid;
        pulse_t p;
        prev_valid = 1'b0;
        forever begin
            @(negedge clock);
            if (reset_n) begin
                if (out_valid && !prev_valid) begin
                    if (rise_q.size() == 0)
                        check_output("valid_rise_pending", rise_q.size(), 1);
                    else
                        check_output("valid_rise_cycle", cyc, rise_q.pop_front());
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0)
                        check_output("word_pending", exp_q.size(), 1);
                    else
                        check_output("out_data", out_data, exp_q.pop_front());
                end
                if (parity_err || overflow) begin
                    if (pulse_q.size() == 0) begin
                        check_output("pulse_pending", pulse_q.size(), 1);
                    end else begin
                        p = pulse_q.pop_front();
                        check_output("pulse_cycle", cyc, p.cyc);
                        check_output("pulse_kind", {parity_err, overflow}, p.ovf ? 2'b01 : 2'b10);
                    end
                end
            end
            prev_valid = out_valid;
        end
    end

    task automatic apply_stimulus(input bit b, input int gap_pct, input bit rdy);
        while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
            bit_valid = 1'b0;
            bit_in    = 1'($urandom_range(1));
            out_ready = rdy;
            @(posedge clock); #1;
        end
        bit_valid = 1'b1;
        bit_in    = b;
        out_ready = rdy;
        @(posedge clock); #1;
        bit_valid = 1'b0;
    endtask

    task automatic send_bits(input logic [31:0] v, input int n, input int gap, input bit rdy);
        for (int i = n - 1; i >= 0; i--)
            apply_stimulus(v[i % 32], gap, rdy);
    endtask

    task automatic send_frame(input logic [DATA_W-1:0] d, input bit bad, input int gap,
                              input bit rdy, input bit rdy_parity);
        send_bits(32'(SYNC), SYNC_W, gap, rdy);
        send_bits(32'(d), DATA_W, gap, rdy);
        apply_stimulus((^d) ^ bad, gap, rdy_parity);
    endtask

    task automatic idle(input int n, input bit rdy);
        bit_valid = 1'b0;
        out_ready = rdy;
        repeat (n) begin
            @(posedge clock); #1;
        end
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        bit_valid = 1'b0;
        out_ready = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b1;
    endtask

    task automatic end_phase(input int expected_frames);
        int t;
        t = 0;
        bit_valid = 1'b0;
        out_ready = 1'b1;
        while ((exp_q.size() > 0 || model_cnt > 0) && t < 100) begin
            @(posedge clock); #1;
            t++;
        end
        idle(3, 1'b0);
        check_output("frame_cnt_model", frame_cnt, model_frames);
        if (expected_frames >= 0)
            check_output("frame_cnt_expected", frame_cnt, expected_frames);
        check_output("words_left", exp_q.size(), 0);
        check_output("pulses_left", pulse_q.size(), 0);
        check_output("rises_left", rise_q.size(), 0);
    endtask

    initial begin
        @(posedge clock); #1;
        for (int i = 0; i < 4; i++) begin
            bit_in    = 1'($urandom_range(1));
            bit_valid = 1'($urandom_range(1));
            out_ready = 1'($urandom_range(1));
            @(negedge clock);
            check_output("reset_out_valid", out_valid, 0);
            check_output("reset_parity_err", parity_err, 0);
            check_output("reset_overflow", overflow, 0);
            check_output("reset_frame_cnt", frame_cnt, 0);
            @(posedge clock); #1;
        end
        reset_n = 1'b1;
        send_bits(32'd0, 30, 0, 1'b1);
        end_phase(0);

        do_reset();
        send_frame(8'h3C, 1'b0, 0, 1'b1, 1'b1);
        end_phase(1);

        do_reset();
        send_bits(32'b1010, 4, 0, 1'b1);
        send_frame(8'hF0, 1'b1, 0, 1'b1, 1'b1);
        end_phase(0);

        do_reset();
        for (int d = 1; d <= 5; d++)
            send_frame(DATA_W'(d), 1'b0, 0, 1'b0, 1'b0);
        end_phase(4);

        do_reset();
        for (int d = 1; d <= 4; d++)
            send_frame(DATA_W'(d), 1'b0, 0, 1'b0, 1'b0);
        send_frame(8'h55, 1'b0, 0, 1'b0, 1'b1);
        idle(4, 1'b0);
        end_phase(5);

        do_reset();
        send_frame(8'hC3, 1'b0, 40, 1'b1, 1'b1);
        send_frame(8'h3C, 1'b0, 0, 1'b1, 1'b1);
        end_phase(2);

        do_reset();
        send_bits(32'(SYNC), SYNC_W, 0, 1'b1);
        send_bits(32'b1011, 4, 0, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        check_output("midreset_out_valid", out_valid, 0);
        check_output("midreset_frame_cnt", frame_cnt, 0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        send_frame(8'h96, 1'b0, 0, 1'b1, 1'b1);
        end_phase(1);

        do_reset();
        repeat (40) begin
            bit r;
            r = 1'($urandom_range(1));
            send_bits($urandom, $urandom_range(12), 20, r);
            send_frame(DATA_W'($urandom), ($urandom_range(99) < 20), ($urandom_range(1) == 1) ? 30 : 0,
                       r, 1'($urandom_range(1)));
        end
        end_phase(-1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule
